// File: rtl/ccff_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
package ccff_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_CHECK,
    ST_DONE
  } state_t;

  localparam logic [7:0] CCFF_MARKER = 8'hA5;
  localparam int         MARKER_LEN  = 8;

  function automatic logic marker_bit(input logic [2:0] idx);
    return CCFF_MARKER[idx];
  endfunction

endpackage

// File: rtl/ccff_piso.sv
// Word-wide parallel-in/serial-out buffer; bit 0 leaves first, last flags the final bit of a word.
module ccff_piso #(
  parameter int WORD_W = 32,
  parameter int IDX_W  = $clog2(WORD_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              shift,
  input  logic [WORD_W-1:0] data,
  input  logic [IDX_W-1:0]  load_idx,
  output logic              bit0,
  output logic              last
);

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WORD_W - 1);

  logic [WORD_W-1:0] sreg;
  logic [IDX_W-1:0]  idx;

  // A short payload (the marker) starts part-way through the index range so last still fires on time.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (load) begin
      idx <= load_idx;
    end else if (shift) begin
      idx <= (idx == IDX_MAX) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      sreg <= data;
    end else if (shift) begin
      sreg <= sreg >> 1;
    end
  end

  assign bit0 = sreg[0];
  assign last = (idx == IDX_MAX);

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises host words onto the ccff chain head with a gated-clock enable.
// Define CCFF_MARKER_CHECK_EN to prepend marker 0xA5 and verify it at ccff_tail.
module ccff_chain_loader
  import ccff_loader_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int LEN_W  = 20
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [WORD_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic              ccff_head,
  output logic              ccff_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int             IDX_W     = $clog2(WORD_W);
  localparam logic [LEN_W:0] WORD_STEP = (LEN_W+1)'(WORD_W);

  state_t            state;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W:0]    total_q;
  logic [LEN_W:0]    bit_cnt;
  logic [LEN_W:0]    fetch_cnt;

  logic              launch;
  logic              need_word;
  logic              accept;
  logic              last_shift;
  logic              marker_load;

  logic              piso_load;
  logic              piso_bit0;
  logic              piso_last;
  logic [WORD_W-1:0] piso_data;
  logic [IDX_W-1:0]  piso_idx;

`ifdef CCFF_MARKER_CHECK_EN
  localparam logic [LEN_W:0] EXTRA       = (LEN_W+1)'(MARKER_LEN);
  localparam state_t         AFTER_START = ST_SHIFT;
  localparam state_t         AFTER_LAST  = ST_CHECK;
  assign marker_load = launch && (cfg_len != '0);
`else
  localparam logic [LEN_W:0] EXTRA       = '0;
  localparam state_t         AFTER_START = ST_FETCH;
  localparam state_t         AFTER_LAST  = ST_DONE;
  assign marker_load = 1'b0;
`endif

  // DONE behaves as idle for a new start, so back-to-back loads lose no cycle.
  assign launch     = start && (state == ST_IDLE || state == ST_DONE);
  assign need_word  = fetch_cnt < {1'b0, len_q};
  assign last_shift = (bit_cnt + 1'b1) == total_q;

  assign wready      = (state == ST_FETCH) || (state == ST_SHIFT && piso_last && need_word);
  assign accept      = wready && wvalid;
  assign ccff_clk_en = (state == ST_SHIFT);
  assign ccff_head   = ccff_clk_en && piso_bit0;
  assign busy        = state inside {ST_FETCH, ST_SHIFT, ST_CHECK};
  assign done        = (state == ST_DONE);

  assign piso_load = marker_load || accept;
  assign piso_data = marker_load ? WORD_W'(CCFF_MARKER) : wdata;
  assign piso_idx  = marker_load ? IDX_W'(WORD_W - MARKER_LEN) : '0;

  ccff_piso #(
    .WORD_W (WORD_W),
    .IDX_W  (IDX_W)
  ) u_piso (
    .clk      (prog_clk),
    .rst      (prog_reset),
    .load     (piso_load),
    .shift    (ccff_clk_en),
    .data     (piso_data),
    .load_idx (piso_idx),
    .bit0     (piso_bit0),
    .last     (piso_last)
  );

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      total_q   <= '0;
      bit_cnt   <= '0;
      fetch_cnt <= '0;
    end else if (launch) begin
      len_q     <= cfg_len;
      total_q   <= {1'b0, cfg_len} + EXTRA;
      bit_cnt   <= '0;
      fetch_cnt <= '0;
      state     <= (cfg_len == '0) ? ST_DONE : AFTER_START;
    end else begin
      case (state)
        ST_FETCH: begin
          if (accept) begin
            fetch_cnt <= fetch_cnt + WORD_STEP;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          bit_cnt <= bit_cnt + 1'b1;
          if (accept) begin
            fetch_cnt <= fetch_cnt + WORD_STEP;
          end
          if (last_shift) begin
            state <= AFTER_LAST;
          end else if (piso_last && !accept) begin
            state <= ST_FETCH;
          end
        end
        ST_CHECK: state <= ST_DONE;
        ST_DONE:  state <= ST_IDLE;
        default:  state <= ST_IDLE;
      endcase
    end
  end

`ifdef CCFF_MARKER_CHECK_EN
  logic [LEN_W:0] chk_off;
  logic           chk_vld_p0;
  logic           tail_p0;
  logic           exp_p0;
  logic           err_q;

  // The marker reaches the tail once bit_cnt equals the chain length; the window spans its 8 bits.
  assign chk_off = bit_cnt - {1'b0, len_q};

  always_ff @(posedge prog_clk or posedge prog_reset) begin
    if (prog_reset) begin
      chk_vld_p0 <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      chk_vld_p0 <= (state == ST_FETCH || state == ST_SHIFT) &&
                    (bit_cnt >= {1'b0, len_q}) && (chk_off < EXTRA);
      if (launch) begin
        err_q <= 1'b0;
      end else if (chk_vld_p0 && (tail_p0 != exp_p0)) begin
        err_q <= 1'b1;
      end
    end
  end

  // ---- stage p0: tail sample and expected marker bit ----
  always_ff @(posedge prog_clk) begin
    tail_p0 <= ccff_tail;
    exp_p0  <= marker_bit(chk_off[2:0]);
  end

  assign err = err_q;
`else
  logic unused_tail;
  assign unused_tail = ccff_tail;
  assign err         = 1'b0;
`endif

endmodule

// File: doc/ccff_chain_loader.md
Name: ccff_chain_loader

Overview:
- Host-side driver for the configuration-chain (ccff) protocol that feeds the grid tiles' `ccff_head`, and the other end of the chain from the tiles.
- Accepts configuration words from a host, latches a chain length and serialises exactly that many bits onto `ccff_head`.
- Drives `ccff_clk_en`, which an external clock gate uses to produce the tiles' gated programming clock. One enabled cycle is one chain shift.
- Optionally verifies chain integrity by watching `ccff_tail`.

Parameters:
- WORD_W, 32, host word width in bits.
- LEN_W, 20, width of the chain-length field; maximum chain length is 2^LEN_W-1.

Ports:
- prog_clk  input  1  programming clock; all state is on the rising edge.
- prog_reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; ignored while busy=1.
- cfg_len  input  LEN_W  chain length N in bits; sampled on start.
- wdata  input  WORD_W  configuration word; bit 0 is shifted first.
- wvalid  input  1  wdata is valid.
- wready  output  1  loader accepts wdata this cycle.
- ccff_head  output  1  serial bit into the chain head.
- ccff_clk_en  output  1  chain shifts at the end of this cycle.
- ccff_tail  input  1  serial bit out of the chain tail.
- busy  output  1  a load is in progress.
- done  output  1  one-cycle completion pulse.
- err  output  1  integrity failure; valid from done and held until the next accepted start.

Behaviour:
- Reset: the clock is prog_clk; reset is prog_reset, asynchronous and active-high.
  - Reset forces the IDLE state and drives wready, ccff_head, ccff_clk_en, busy, done and err to 0.
  - A reset mid-load abandons the load. Chain contents are then undefined, and the host must restart.
- States: IDLE -> FETCH -> SHIFT -> (CHECK) -> DONE -> IDLE.
- IDLE:
  - On start, latch N=cfg_len, clear the bit and word counters, and clear err.
  - busy=1 from the next cycle.
  - If N=0, go directly to DONE: done is pulsed in the cycle after start and there is no shift.
- FETCH:
  - wready=1. A handshake (wvalid&&wready) loads the 32-bit buffer, then go to SHIFT.
- SHIFT:
  - ccff_head = buffer bit 0 and ccff_clk_en=1. Each cycle the buffer shifts right and the bit counter increments.
  - wready is also 1 during the last bit of a word, so a word arriving that cycle continues the shifting with no bubble. Sustained rate is one bit per cycle while wvalid stays high.
  - If the buffer empties with no word available, go to FETCH with ccff_clk_en=0 (a stall). Stalls never shift the chain.
- Bit count:
  - Exactly N shifts are performed (N+8 with the optional feature).
  - Words needed = ceil(N/WORD_W). Unused upper bits of the final word are discarded.
  - No further wready is issued once the needed words have been accepted.
- DONE:
  - done=1 for exactly one cycle, the cycle after the last shift cycle (after CHECK when the feature is compiled in). busy=0 from the same cycle.
- Counters:
  - The bit counter is LEN_W+1 bits wide to cover N+8 without wrap.
  - The in-word index wraps at WORD_W-1.
- start while busy=1: ignored, with no effect on state.

Optional Feature:
- Macro: CCFF_MARKER_CHECK_EN.
- Enabled:
  - Before the data, the loader shifts the 8-bit marker 0xA5, LSB first. These are shifts 1..8 and need no host word.
  - The data then follows, for N+8 shifts in total.
  - The cycle after each shift is numbered s (1-based). For s=N+i, i=0..7, ccff_tail is registered and compared with marker bit i.
  - Any mismatch sets sticky err.
  - A CHECK state covers the final comparison cycle after shift N+8. done follows CHECK.
- Disabled:
  - Exactly N shifts, ccff_tail is unused, and err is tied to 0.

Decomposition:
- Package ccff_loader_pkg holds:
  - the state enumeration;
  - CCFF_MARKER = 8'hA5;
  - MARKER_LEN = 8.
- One sub-module, ccff_piso: a WORD_W-bit parallel-in/serial-out buffer with load, shift, bit-0 output and an empty/last-bit flag.
- The FSM and counters stay in the top.

Test Plan:
- N=5, wdata=0x15 held valid: ccff_head = 1,0,1,0,1 over 5 consecutive ccff_clk_en cycles, one wready handshake, done exactly one cycle later, err=0.
- N=70, WORD_W=32, three words with wvalid low for 4 cycles between words: ccff_clk_en counts exactly 70 and drops during each gap, 3 handshakes, bits 70..95 of the stream are never shifted.
- cfg_len=0 with start: done in the next cycle, no ccff_clk_en, no wready.
- prog_reset asserted at shift 17 of N=40: all outputs 0 immediately; a subsequent start with N=40 produces 40 clean shifts.
- Feature on, behavioural 10-bit chain model on ccff_head/ccff_tail, N=10: 18 shifts, err=0, done one cycle after CHECK. Same test with ccff_tail stuck at 0: err=1 at done.
- start pulsed during an active load of N=32: ignored, and the total shift count stays 32 (40 with the feature).
